multi_mode_counter: RTL and testbench

4-bit multi-mode up/down game counter. Each clock it loads or steps the count by ±1/±2, per a 2-bit mode, with modulo-16 wrap. Reaching 15 is a win and reaching 0 is a loss. The block tallies wins and losses and declares a game-over winner when either tally reaches 15. It sits behind the game-counter interface and is driven directly by the counter testbench agent.

---
 rtl/multi_mode_counter_pkg.sv | 38 +++
 rtl/multi_mode_counter_score_tally.sv | 38 +++
 rtl/multi_mode_counter.sv | 97 +++++++++
 tb/tb_multi_mode_counter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/multi_mode_counter_pkg.sv
// Shared types and constants for the multi-mode game counter.
package multi_mode_counter_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TALLY_W = 4;
  localparam int unsigned CTRL_W  = 2;

  typedef enum logic [CTRL_W-1:0] {
    UP1 = 2'b00,
    UP2 = 2'b01,
    DN1 = 2'b10,
    DN2 = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    WHO_NONE   = 2'b00,
    WHO_LOSER  = 2'b01,
    WHO_WINNER = 2'b10
  } who_e;

  localparam logic [CNT_W-1:0]   CNT_MAX     = 4'hF;
  localparam logic [CNT_W-1:0]   CNT_MIN     = 4'h0;
  localparam logic [TALLY_W-1:0] TALLY_LIMIT = 4'd15;

  // Modulo-16 step of the count; the 4-bit width provides the wrap.
  function automatic logic [CNT_W-1:0] step_count(input logic [CNT_W-1:0] cur,
                                                  input ctrl_e ctrl);
    logic [CNT_W-1:0] nxt;
    case (ctrl)
      UP1:     nxt = cur + CNT_W'(1);
      UP2:     nxt = cur + CNT_W'(2);
      DN1:     nxt = cur - CNT_W'(1);
      default: nxt = cur - CNT_W'(2);
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multi_mode_counter_score_tally.sv
// Saturation-free 4-bit score tally; clear wins over increment.
module multi_mode_counter_score_tally
  import multi_mode_counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_i,
  input  logic               clear_i,
  output logic [TALLY_W-1:0] count_o,
  output logic               at_limit_c
);

  logic [TALLY_W-1:0] tally_q;
  logic [TALLY_W-1:0] tally_d;

  // Next tally value; at_limit looks at the value about to be registered.
  always_comb begin
    tally_d = tally_q;
    if (clear_i) begin
      tally_d = '0;
    end else if (inc_i) begin
      tally_d = tally_q + TALLY_W'(1);
    end
    at_limit_c = (tally_d == TALLY_LIMIT);
  end

  // Tally register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tally_q <= '0;
    end else begin
      tally_q <= tally_d;
    end
  end

  assign count_o = tally_q;

endmodule

// File: rtl/multi_mode_counter.sv
// 4-bit up/down game counter with win/loss tallies and game-over detection.
module multi_mode_counter
  import multi_mode_counter_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               INIT,
  input  logic [CNT_W-1:0]   load,
  input  logic [CTRL_W-1:0]  CONTROL,
  output logic [CNT_W-1:0]   count,
  output logic               WINNER,
  output logic               LOSER,
  output logic [TALLY_W-1:0] count_winner,
  output logic [TALLY_W-1:0] count_loser,
  output logic               GAMEOVER,
  output logic [1:0]         WHO
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             winner_q, winner_d;
  logic             loser_q, loser_d;
  logic             gameover_q, gameover_d;
  who_e             who_q, who_d;
  logic             win_lim_c;
  logic             lose_lim_c;

  // Count update and outcome decode; a game-over cycle only clears.
  always_comb begin
    count_d  = count_q;
    winner_d = 1'b0;
    loser_d  = 1'b0;
    if (gameover_q) begin
      count_d = CNT_MIN;
    end else begin
      count_d  = INIT ? load : step_count(count_q, ctrl_e'(CONTROL));
      loser_d  = (count_d == CNT_MIN);
      winner_d = (count_d == CNT_MAX) && !loser_d;
    end
  end

  // Game-over decision from the post-increment tallies; wins take precedence.
  always_comb begin
    gameover_d = 1'b0;
    who_d      = WHO_NONE;
    if (!gameover_q) begin
      if (win_lim_c) begin
        gameover_d = 1'b1;
        who_d      = WHO_WINNER;
      end else if (lose_lim_c) begin
        gameover_d = 1'b1;
        who_d      = WHO_LOSER;
      end
    end
  end

  // Count, pulse and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q    <= CNT_MIN;
      winner_q   <= 1'b0;
      loser_q    <= 1'b0;
      gameover_q <= 1'b0;
      who_q      <= WHO_NONE;
    end else begin
      count_q    <= count_d;
      winner_q   <= winner_d;
      loser_q    <= loser_d;
      gameover_q <= gameover_d;
      who_q      <= who_d;
    end
  end

  multi_mode_counter_score_tally u_win_tally (
    .clk        (CLK),
    .rst        (RST),
    .inc_i      (winner_d),
    .clear_i    (gameover_q),
    .count_o    (count_winner),
    .at_limit_c (win_lim_c)
  );

  multi_mode_counter_score_tally u_lose_tally (
    .clk        (CLK),
    .rst        (RST),
    .inc_i      (loser_d),
    .clear_i    (gameover_q),
    .count_o    (count_loser),
    .at_limit_c (lose_lim_c)
  );

  assign count    = count_q;
  assign WINNER   = winner_q;
  assign LOSER    = loser_q;
  assign GAMEOVER = gameover_q;
  assign WHO      = who_q;

endmodule

// File: tb/tb_multi_mode_counter.sv
// Directed bench for multi_mode_counter: vector table plus corner sequences.
module tb_multi_mode_counter;

  logic       CLK;
  logic       RST;
  logic       INIT;
  logic [3:0] load;
  logic [1:0] CONTROL;
  logic [3:0] count;
  logic       WINNER;
  logic       LOSER;
  logic [3:0] count_winner;
  logic [3:0] count_loser;
  logic       GAMEOVER;
  logic [1:0] WHO;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        init;
    logic [3:0]  ld;
    logic [1:0]  ctrl;
    logic [16:0] exp;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  multi_mode_counter dut (
    .CLK          (CLK),
    .RST          (RST),
    .INIT         (INIT),
    .load         (load),
    .CONTROL      (CONTROL),
    .count        (count),
    .WINNER       (WINNER),
    .LOSER        (LOSER),
    .count_winner (count_winner),
    .count_loser  (count_loser),
    .GAMEOVER     (GAMEOVER),
    .WHO          (WHO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Pack expected outputs: {count, WINNER, LOSER, cw, cl, GAMEOVER, WHO}.
  function automatic logic [16:0] e(input logic [3:0] c, input logic w, input logic l,
                                    input logic [3:0] cw, input logic [3:0] cl,
                                    input logic go, input logic [1:0] who);
    return {c, w, l, cw, cl, go, who};
  endfunction

  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = {count, WINNER, LOSER, count_winner, count_loser, GAMEOVER, WHO};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got count=%0d W=%0b L=%0b cw=%0d cl=%0d go=%0b who=%0d, want count=%0d W=%0b L=%0b cw=%0d cl=%0d go=%0b who=%0d",
               name, act[16:13], act[12], act[11], act[10:7], act[6:3], act[2], act[1:0],
               exp[16:13], exp[12], exp[11], exp[10:7], exp[6:3], exp[2], exp[1:0]);
    end
  endtask

  // Apply inputs, take one rising edge, settle 1 ns past it.
  task automatic step(input logic init, input logic [3:0] ld, input logic [1:0] ctrl);
    INIT    = init;
    load    = ld;
    CONTROL = ctrl;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    #1;
    check("async_reset", e(4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00));
    #1;
    RST = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    RST     = 1'b1;
    INIT    = 1'b0;
    load    = 4'd0;
    CONTROL = 2'b00;

    vecs[0]  = '{1'b1, 4'd13, 2'b00, e(4'd13, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00)};
    vecs[1]  = '{1'b0, 4'd0,  2'b00, e(4'd14, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00)};
    vecs[2]  = '{1'b0, 4'd0,  2'b00, e(4'd15, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 2'b00)};
    vecs[3]  = '{1'b0, 4'd0,  2'b00, e(4'd0,  1'b0, 1'b1, 4'd1, 4'd1, 1'b0, 2'b00)};
    vecs[4]  = '{1'b1, 4'd1,  2'b00, e(4'd1,  1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 2'b00)};
    vecs[5]  = '{1'b0, 4'd0,  2'b11, e(4'd15, 1'b1, 1'b0, 4'd2, 4'd1, 1'b0, 2'b00)};
    vecs[6]  = '{1'b0, 4'd0,  2'b10, e(4'd14, 1'b0, 1'b0, 4'd2, 4'd1, 1'b0, 2'b00)};
    vecs[7]  = '{1'b0, 4'd0,  2'b01, e(4'd0,  1'b0, 1'b1, 4'd2, 4'd2, 1'b0, 2'b00)};
    vecs[8]  = '{1'b0, 4'd0,  2'b11, e(4'd14, 1'b0, 1'b0, 4'd2, 4'd2, 1'b0, 2'b00)};
    vecs[9]  = '{1'b1, 4'd0,  2'b01, e(4'd0,  1'b0, 1'b1, 4'd2, 4'd3, 1'b0, 2'b00)};
    vecs[10] = '{1'b1, 4'd0,  2'b01, e(4'd0,  1'b0, 1'b1, 4'd2, 4'd4, 1'b0, 2'b00)};
    vecs[11] = '{1'b1, 4'd0,  2'b01, e(4'd0,  1'b0, 1'b1, 4'd2, 4'd5, 1'b0, 2'b00)};
    vecs[12] = '{1'b0, 4'd0,  2'b01, e(4'd2,  1'b0, 1'b0, 4'd2, 4'd5, 1'b0, 2'b00)};
    vecs[13] = '{1'b0, 4'd0,  2'b10, e(4'd1,  1'b0, 1'b0, 4'd2, 4'd5, 1'b0, 2'b00)};
    vecs[14] = '{1'b0, 4'd0,  2'b10, e(4'd0,  1'b0, 1'b1, 4'd2, 4'd6, 1'b0, 2'b00)};
    vecs[15] = '{1'b1, 4'd15, 2'b10, e(4'd15, 1'b1, 1'b0, 4'd3, 4'd6, 1'b0, 2'b00)};
    vecs[16] = '{1'b1, 4'd15, 2'b10, e(4'd15, 1'b1, 1'b0, 4'd4, 4'd6, 1'b0, 2'b00)};

    // Power-on reset state.
    #12;
    check("reset_state", e(4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00));
    @(negedge CLK);
    RST = 1'b0;

    // Vector table: wraps, steps in all modes, held load of zero and fifteen.
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].init, vecs[i].ld, vecs[i].ctrl);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Mid-game async reset, then count resumes from zero.
    pulse_reset();
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 4'd0, 2'b00);
      check($sformatf("post_reset_up%0d", k), e(4'(k), 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00));
    end

    // Fifteen wins: game over on the last, then a full clear.
    for (int k = 1; k <= 15; k++) begin
      step(1'b1, 4'd15, 2'b00);
      check($sformatf("win%0d", k),
            e(4'd15, 1'b1, 1'b0, 4'(k), 4'd0, (k == 15), (k == 15) ? 2'b10 : 2'b00));
    end
    step(1'b1, 4'd15, 2'b00);
    check("win_clear", e(4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00));
    step(1'b1, 4'd15, 2'b00);
    check("win_resume", e(4'd15, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 2'b00));

    // Fifteen losses from a clean start.
    pulse_reset();
    for (int k = 1; k <= 15; k++) begin
      step(1'b1, 4'd0, 2'b00);
      check($sformatf("loss%0d", k),
            e(4'd0, 1'b0, 1'b1, 4'd0, 4'(k), (k == 15), (k == 15) ? 2'b01 : 2'b00));
    end
    step(1'b1, 4'd0, 2'b00);
    check("loss_clear", e(4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00));
    step(1'b0, 4'd0, 2'b00);
    check("loss_resume", e(4'd1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
